// File: rtl/imm_ext_pipe.sv
// SPARC immediate / branch-target extender feeding an in-order output FIFO.
// The head entry is held in registers so out_data keeps its last value when the FIFO drains.
module imm_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             ir,
  input  logic [DATA_W-1:0]       pc,
  input  logic [2:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_ovf,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int MSB = DATA_W - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (!((DATA_W == 32) || (DATA_W == 64))) begin : g_bad_data_w
    $error("imm_ext_pipe: DATA_W must be 32 or 64");
  end
  if ((DEPTH < 2) || (DEPTH > 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("imm_ext_pipe: DEPTH must be a power of two in 2..8");
  end

  function automatic logic [DATA_W-1:0] sext32(input logic [31:0] v);
    logic [DATA_W-1:0] r;
    r       = {DATA_W{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext32(input logic [31:0] v);
    logic [DATA_W-1:0] r;
    r       = {DATA_W{1'b0}};
    r[31:0] = v;
    return r;
  endfunction

  logic [DATA_W:0]     mem_q [DEPTH];
  logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_ovf_q, out_ovf_d;
  logic [DATA_W-1:0]   ent_data_d, tgt_off_s, sum_s;
  logic                ent_ovf_d, tgt_add_s;
  logic [31:0]         off22_s, off30_s;
  logic                push_s, pop_s;
  logic                ir_unused_s;

  assign ir_unused_s = ^ir[31:30];

  assign in_ready  = !reset && ((count_q < DEPTH_C) || out_ready);
  assign out_valid = (count_q != {CW{1'b0}});
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign count     = count_q;

  assign off22_s = {{8{ir[21]}}, ir[21:0], 2'b00};
  assign off30_s = {ir[29:0], 2'b00};
  assign sum_s   = pc + tgt_off_s;

  // Extended immediate / target selection for the entry offered this cycle.
  always_comb begin
    ent_data_d = {DATA_W{1'b0}};
    ent_ovf_d  = 1'b0;
    tgt_off_s  = {DATA_W{1'b0}};
    tgt_add_s  = 1'b0;
    case (mode)
      3'd0:    ent_data_d = sext32({{19{ir[12]}}, ir[12:0]});
      3'd1:    ent_data_d = sext32({{10{ir[21]}}, ir[21:0]});
      3'd2:    ent_data_d = sext32({{2{ir[29]}}, ir[29:0]});
      3'd3:    ent_data_d = sext32(off30_s);
      3'd4:    ent_data_d = zext32({10'b0, ir[21:0]});
      3'd5:    ent_data_d = sext32(off22_s);
      3'd6: begin
        tgt_off_s = sext32(off22_s);
        tgt_add_s = 1'b1;
      end
      3'd7: begin
        tgt_off_s = sext32(off30_s);
        tgt_add_s = 1'b1;
      end
      default: ent_data_d = {DATA_W{1'b0}};
    endcase
    if (tgt_add_s) begin
      ent_data_d = sum_s;
      ent_ovf_d  = (pc[MSB] == tgt_off_s[MSB]) && (sum_s[MSB] != pc[MSB]);
    end else begin
      ent_ovf_d  = 1'b0;
    end
  end

  // Pointer/occupancy next state, plus the entry that will sit at the head after this edge.
  always_comb begin
    rd_d       = pop_s  ? rd_q + PW'(1) : rd_q;
    wr_d       = push_s ? wr_q + PW'(1) : wr_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A write landing on the new read slot means the incoming entry becomes the head.
    if (count_d != {CW{1'b0}}) begin
      if (push_s && (wr_q == rd_d)) begin
        {out_ovf_d, out_data_d} = {ent_ovf_d, ent_data_d};
      end else begin
        {out_ovf_d, out_data_d} = mem_q[rd_d];
      end
    end else begin
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q] <= {ent_ovf_d, ent_data_d};
    end
  end

  // Control and head registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q       <= {PW{1'b0}};
      wr_q       <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      out_data_q <= {DATA_W{1'b0}};
      out_ovf_q  <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter DATA_W, default 32: output datapath width; legal values are 32 and 64, and other values SHALL fail elaboration.
REQ-002 Parameter DEPTH, default 2: output buffer entries; legal range is 2..8, and it SHALL be a power of two.
REQ-003 Clocking SHALL be one clock, clk; reset SHALL be synchronous, active-high, named reset.
REQ-004 clk, input, 1 bit: rising-edge clock for all state.
REQ-005 reset, input, 1 bit: synchronous, active-high clear.
REQ-006 in_valid, input, 1 bit: an instruction is offered this cycle.
REQ-007 in_ready, output, 1 bit: the block accepts the offered instruction this cycle.
REQ-008 ir, input, 32 bits: SPARC instruction word.
REQ-009 pc, input, DATA_W bits: PC of the instruction, used by modes 6 and 7.
REQ-010 mode, input, 3 bits: extension mode select (see REQ-014).
REQ-011 out_valid, output, 1 bit: out_data and out_ovf are valid.
REQ-012 out_ready, input, 1 bit: the consumer takes the head entry.
REQ-013 out_data, output, DATA_W bits: extended immediate or target.
REQ-013a out_ovf, output, 1 bit: the target computation wrapped past DATA_W (modes 6 and 7 only; 0 otherwise).
REQ-013b count, output, $clog2(DEPTH)+1 bits: current buffer occupancy.

Function
REQ-014 The mode encoding SHALL produce these results (sext = sign-extend to DATA_W, zext = zero-extend to DATA_W):
- 0: sext(ir[12:0]).
- 1: sext(ir[21:0]).
- 2: sext(ir[29:0]).
- 3: sext({ir[29:0],2'b00}).
- 4: zext(ir[21:0]).
- 5: sext({ir[21:0],2'b00}).
- 6: pc + sext({ir[21:0],2'b00}).
- 7: pc + sext({ir[29:0],2'b00}).
REQ-015 Modes 6 and 7 SHALL use modulo-2^DATA_W addition.
REQ-016 out_ovf SHALL be 1 when the signed addition overflows, i.e. pc[msb] equals offset[msb] and the sum's msb differs from it.
REQ-017 A transfer in SHALL occur exactly when in_valid && in_ready is high at a rising clk edge.
REQ-018 A transfer out SHALL occur exactly when out_valid && out_ready is high at a rising clk edge.
REQ-019 Operands SHALL be computed combinationally from ir, pc and mode and written into the buffer on a transfer in.
REQ-020 Latency: an entry accepted at edge N SHALL be visible on out_data/out_valid after edge N, i.e. in cycle N+1.
REQ-021 The buffer SHALL be an in-order FIFO: out_data and out_ovf always reflect the oldest entry, with no reordering and no drops.
REQ-022 in_ready SHALL equal (count < DEPTH) || out_ready (pass-through when full).
REQ-023 in_ready SHALL be combinational from count and out_ready only, never from in_valid.
REQ-024 out_valid SHALL equal (count != 0); there is no bypass from input to output in the same cycle.
REQ-025 Occupancy SHALL update per edge as follows:
- count increments on transfer in only;
- count decrements on transfer out only;
- count is unchanged on simultaneous transfer in and out, with the read pointer and write pointer both advancing.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow below 0.
REQ-027 With count == DEPTH and out_ready = 0, in_ready SHALL be 0 and the stored contents SHALL be held unchanged.
REQ-028 With count == 0, out_data SHALL hold its last value and a deasserted out_ready SHALL have no effect.
REQ-029 out_data and out_ovf SHALL remain stable while out_valid = 1 and out_ready = 0.

Reset
REQ-030 When reset = 1 at an edge, the block SHALL set count = 0, both pointers = 0, out_valid = 0, out_data = 0 and out_ovf = 0.
REQ-031 Reset SHALL have priority over any simultaneous transfer.
REQ-032 Reset SHALL discard in-flight entries.
REQ-033 in_ready SHALL be 0 while reset = 1.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 Mode sweep, DATA_W=32: ir=0x00001FFF, mode 0 -> out_data=0xFFFFFFFF one cycle later; ir=0x00200000, mode 5 -> 0xFF800000; ir=0x00200000, mode 4 -> 0x00200000.
REQ-036 Target: pc=0x00001000, ir[29:0]=0x3FFFFFFF, mode 7 -> out_data=0x00000FFC, out_ovf=0.
REQ-037 Overflow: pc=0x7FFFFFFC, ir[21:0]=0x000001, mode 6 -> out_data=0x80000000, out_ovf=1.
REQ-038 Backpressure, DEPTH=2: out_ready=0, send 3 words -> the third is stalled with in_ready=0 and count=2; raise out_ready -> words emerge in order and the third is accepted the same cycle as the first pop.
REQ-039 Simultaneous push and pop at count=1 for 10 cycles -> count stays 1 and the output sequence equals the input sequence delayed by one.
REQ-040 Reset asserted with count=2 -> next cycle count=0, out_valid=0, out_data=0, and the old entries never appear on the output.
